// File: rtl/core_pkg.sv
// Shared MIPS core constants: PC geometry, reset vector, bubble word and the
// opcode/funct encodings decoded by controlUnit.
package core_pkg;

  localparam int unsigned PC_W      = 32;
  localparam logic [PC_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, imem port, IF/ID outputs.
interface fetch_stage_if;
  import core_pkg::*;

  logic            stall;
  logic            flush;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic            jr;
  logic [PC_W-1:0] jr_addr;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [31:0]     if_id_instr;
  logic [PC_W-1:0] if_id_pc4;
  logic            if_id_valid;
  logic [5:0]      if_id_opcode;
  logic [5:0]      if_id_funct;
  logic [31:0]     fetch_count;

  modport master (
    output stall, flush, branch_taken, branch_target, jump, jr, jr_addr, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, if_id_opcode, if_id_funct,
           fetch_count
  );

  modport slave (
    input  stall, flush, branch_taken, branch_target, jump, jr, jr_addr, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, if_id_opcode, if_id_funct,
           fetch_count
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: branch > stall > jr > j/jal > sequential.
module fetch_next_pc
  import core_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            stall_i,
  input  logic            jump_i,
  input  logic            jr_i,
  input  logic [PC_W-1:0] jr_addr_i,
  input  logic [3:0]      pc4_hi_i,
  input  logic [25:0]     instr_index_i,
  output logic [PC_W-1:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_plus4(pc_i);
    // Branch in EX is older than the stalled instruction, so it beats stall.
    if (branch_taken_i) begin
      next_pc_o = branch_target_i;
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end else if (jump_i && jr_i) begin
      next_pc_o = jr_addr_i;
    end else if (jump_i) begin
      next_pc_o = {pc4_hi_i, instr_index_i, 2'b00};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register and fetch counter.
module fetch_stage
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.slave bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic [31:0]     count_q, count_d;
  logic            squash;

  fetch_next_pc u_next_pc (
    .pc_i            (pc_q),
    .branch_taken_i  (bus.branch_taken),
    .branch_target_i (bus.branch_target),
    .stall_i         (bus.stall),
    .jump_i          (bus.jump),
    .jr_i            (bus.jr),
    .jr_addr_i       (bus.jr_addr),
    .pc4_hi_i        (pc4_q[PC_W-1:PC_W-4]),
    .instr_index_i   (instr_q[25:0]),
    .next_pc_o       (pc_d)
  );

  // A stalled jump stays in ID, so the slot behind it is not yet wrong-path.
  assign squash = bus.branch_taken || bus.flush || (bus.jump && !bus.stall);

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (squash) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      instr_d = bus.imem_rdata;
      pc4_d   = pc_plus4(pc_q);
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.if_id_instr  = instr_q;
  assign bus.if_id_pc4    = pc4_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.if_id_opcode = instr_q[31:26];
  assign bus.if_id_funct  = instr_q[5:0];
  assign bus.fetch_count  = count_q;

endmodule
